mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the E stage of the five-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issues and owns the HI/LO registers.
- Models fixed multi-cycle latencies with a busy counter.
- Generates the D-stage stall request so the hazard unit holds any MDU-using instruction while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  E-stage instruction is an MDU op; qualifies md_op
md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved
rs_val  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
rt_val  input  32  forwarded rt operand (divisor / multiplier)
md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  output  1  multi-cycle operation in flight
done  output  1  single-cycle pulse in the final busy cycle
stall_D  output  1  stall request to the hazard unit
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, stall_D=0. Reset mid-operation abandons the op; HI/LO stay 0.
- States:
  - IDLE, MUL, DIV.
  - cnt is a 4-bit down-counter.
  - busy = (state != IDLE).
- IDLE with start=1 and md_op in {0,1}:
  - Compute the 64-bit product from rs_val/rt_val (signed for op 0, unsigned for op 1).
  - Latch the product into internal pending registers.
  - cnt <= MULT_CYCLES, state <= MUL.
- IDLE with start=1 and md_op in {2,3}:
  - Latch quotient/remainder into pending registers.
  - cnt <= DIV_CYCLES, state <= DIV.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divisor 0: a pending "no-write" flag is set; the full DIV_CYCLES busy still applies; HI/LO are left unchanged at completion.
- MUL/DIV: cnt decrements each cycle.
  - When cnt==1, done=1 for that cycle.
  - At the closing edge of that cycle: hi <= pending_hi and lo <= pending_lo (unless no-write), state <= IDLE.
  - busy is therefore high for exactly N cycles: start at cycle t gives busy in cycles t+1..t+N.
  - HI/LO hold the new values in cycle t+N+1.
- mthi/mtlo (start=1, op 4/5) in IDLE: hi or lo <= rs_val at the next edge. No busy, no done.
- start while busy=1: ignored for all ops. The hazard unit guarantees this does not occur; the bench checks that HI/LO and the counter are unaffected.
- Reserved op 6/7 with start=1: ignored.
- stall_D (combinational) = md_use_D & (busy | (start & md_op in {0,1,2,3})).
  - An mfhi/mflo in D is stalled until the cycle after done.
  - No stall for a D-stage MDU instruction when busy=0 and E holds no mult/div.
- hi/lo are plain register outputs. There is no bypass of pending results.

Test Plan:
1. multu rs=0xFFFFFFFF rt=0x00000002 -> busy high exactly 5 cycles, done in the 5th; then hi=0x00000001, lo=0xFFFFFFFE.
2. mult rs=0xFFFFFFFD (-3) rt=0x00000004 -> after 5 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFF4.
3. div rs=0xFFFFFFF9 (-7) rt=0x00000002 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu rs=0x10 rt=0 -> busy 10 cycles, HI/LO unchanged.
4. mthi rs=0x12345678 -> hi=0x12345678 next cycle, busy stays 0. A second start during a running mult is ignored; the mult's result is committed.
5. md_use_D=1 in every cycle of a 5-cycle mult -> stall_D=1 in the start cycle and all 5 busy cycles, 0 in the following cycle. md_use_D=1 with IDLE and no start -> stall_D=0.
6. Assert reset=0 asynchronously in busy cycle 3 of a div -> busy, done, hi, and lo go to 0 immediately. After release, a new mult completes normally.

Source files
------------

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - E-stage multiply/divide controller owning HI/LO with fixed-latency busy timing
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic        busy,
  output logic        done,
  output logic        stall_D,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        nowr_q, nowr_d;

  logic        signed_op;
  logic [63:0] mul_a, mul_b, product;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_b, uquot, urem, quot, rem;

  // Even opcodes (mult, div) are signed; odd (multu, divu) unsigned.
  assign signed_op = ~md_op[0];
  assign mul_a     = {{32{signed_op & rs_val[31]}}, rs_val};
  assign mul_b     = {{32{signed_op & rt_val[31]}}, rt_val};
  assign product   = mul_a * mul_b;

  // Signed divide via magnitudes: truncates toward zero, remainder follows
  // the dividend, and 0x80000000 / -1 falls out as 0x80000000 with no trap.
  assign neg_a = signed_op & rs_val[31];
  assign neg_b = signed_op & rt_val[31];
  assign mag_a = neg_a ? (~rs_val + 32'd1) : rs_val;
  assign mag_b = neg_b ? (~rt_val + 32'd1) : rt_val;
  assign div_b = (rt_val == 32'd0) ? 32'd1 : mag_b;
  assign uquot = mag_a / div_b;
  assign urem  = mag_a % div_b;
  assign quot  = (neg_a ^ neg_b) ? (~uquot + 32'd1) : uquot;
  assign rem   = neg_a ? (~urem + 32'd1) : urem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      nowr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      nowr_q    <= nowr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    nowr_d    = nowr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            3'd0, 3'd1: begin
              pend_hi_d = product[63:32];
              pend_lo_d = product[31:0];
              nowr_d    = 1'b0;
              cnt_d     = 4'(MULT_CYCLES);
              state_d   = MUL;
            end
            3'd2, 3'd3: begin
              pend_hi_d = rem;
              pend_lo_d = quot;
              nowr_d    = (rt_val == 32'd0);
              cnt_d     = 4'(DIV_CYCLES);
              state_d   = DIV;
            end
            3'd4:    hi_d = rs_val;
            3'd5:    lo_d = rs_val;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (!nowr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = busy && (cnt_q == 4'd1);
  assign stall_D = md_use_D & (busy | (start & (md_op < 3'd4)));
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - vector table, corner sequences and randomized model check for mdu_ctrl
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
  logic        md_use_D = 1'b0;
  logic        busy, done, stall_D;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] mhi = 32'd0, mlo = 32'd0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .md_use_D(md_use_D),
    .busy(busy), .done(done), .stall_D(stall_D), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] exp_hi, exp_lo;
    int          cyc;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one op, then follow the busy window checking done/stall placement.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_d, input int exp_cyc);
    int n;
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; md_use_D = use_d;
    #1;
    check("stall_start", stall_D, use_d && (op < 3'd4));
    check("busy_at_issue", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    n = 0;
    while (busy && n < 20) begin
      n++;
      check("done_pos", done, n == exp_cyc);
      if (use_d) check("stall_busy", stall_D, 1'b1);
      @(posedge clk); #2;
    end
    check("busy_cycles", n, exp_cyc);
    if (use_d) check("stall_after", stall_D, 1'b0);
    md_use_D = 1'b0;
  endtask

  function automatic int cycles_of(input logic [2:0] op);
    if (op < 3'd2) return MC;
    if (op < 3'd4) return DC;
    return 0;
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural semantics.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp, sq, sr;
    longint unsigned up;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin sp = sa * sb; p = sp; mhi = p[63:32]; mlo = p[31:0]; end
      3'd1: begin up = longint'(a) * longint'(b); p = up; mhi = p[63:32]; mlo = p[31:0]; end
      3'd2: if (b != 0) begin sq = sa / sb; sr = sa % sb; p = sq; mlo = p[31:0]; p = sr; mhi = p[31:0]; end
      3'd3: if (b != 0) begin mlo = a / b; mhi = a % b; end
      3'd4: mhi = a;
      3'd5: mlo = a;
      default: ;
    endcase
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MC};
    vt[1] = '{3'd0, 32'hFFFFFFFD, 32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFF4, MC};
    vt[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vt[3] = '{3'd3, 32'h00000010, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vt[4] = '{3'd4, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFD, 0};
    vt[5] = '{3'd5, 32'hCAFEF00D, 32'h0,        32'h12345678, 32'hCAFEF00D, 0};
    vt[6] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    vt[7] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DC};
    vt[8] = '{3'd6, 32'hDEADBEEF, 32'h00000003, 32'h0000000F, 32'h0FFFFFFF, 0};
    vt[9] = '{3'd0, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, MC};

    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(posedge clk); #2;
    md_use_D = 1'b1;
    #1;
    check("idle_no_stall", stall_D, 1'b0);
    md_use_D = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, (i == 0), vt[i].cyc);
      check($sformatf("vec%0d_hi", i), hi, vt[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vt[i].exp_lo);
      mhi = vt[i].exp_hi;
      mlo = vt[i].exp_lo;
    end

    // Starts while busy must be ignored; the original mult still commits.
    begin
      int n;
      start = 1'b1; md_op = 3'd1; rs_val = 32'h00010000; rt_val = 32'h00030000;
      @(posedge clk); #1; start = 1'b0; n = 1;
      @(posedge clk); #1; start = 1'b1; md_op = 3'd4; rs_val = 32'hBAD0BAD0; n++;
      @(posedge clk); #1; md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7; n++;
      @(posedge clk); #1; start = 1'b0; #1;
      while (busy && n < 20) begin
        n++;
        @(posedge clk); #2;
      end
      check("ignored_busy_cycles", n, MC);
      check("ignored_hi", hi, 32'h00000003);
      check("ignored_lo", lo, 32'h00000000);
      @(posedge clk); #2;
      check("ignored_no_relaunch", busy, 1'b0);
      mhi = 32'h3; mlo = 32'h0;
    end

    // Async reset in busy cycle 3 of a div.
    start = 1'b1; md_op = 3'd2; rs_val = 32'd1000; rt_val = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    mhi = 32'd0; mlo = 32'd0;
    issue(3'd0, 32'h00000009, 32'hFFFFFFFE, 1'b0, MC);
    check("post_rst_hi", hi, 32'hFFFFFFFF);
    check("post_rst_lo", lo, 32'hFFFFFFEE);
    mhi = 32'hFFFFFFFF; mlo = 32'hFFFFFFEE;

    for (int k = 0; k < 40; k++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h80000000;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
      model(op, a, b);
      issue(op, a, b, 1'($urandom_range(0, 1)), cycles_of(op));
      check($sformatf("rnd%0d_op%0d_hi", k, op), hi, mhi);
      check($sformatf("rnd%0d_op%0d_lo", k, op), lo, mlo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
